// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port pixel framebuffer between display
// scan-out (absolute priority during the active area) and a pixel writer
// whose requests are buffered in a small FIFO and drained on blanking cycles.
// Optional build macro VGA_FB_STALL_STAT_EN adds the stall_count output.
module vga_fb_arbiter #(
  parameter int H_SIZE     = 800,
  parameter int V_SIZE     = 600,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       h_count,
  input  logic [9:0]        v_count,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata,
  output logic [2:0]        rgb
`ifdef VGA_FB_STALL_STAT_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [10:0]       H_LIM    = 11'(H_SIZE);
  localparam logic [9:0]        V_LIM    = 10'(V_SIZE);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_SIZE * V_SIZE - 1);
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    GR_IDLE  = 2'd0,
    GR_SCAN  = 2'd1,
    GR_WRITE = 2'd2
  } grant_t;

  grant_t            w_grant;
  logic              w_active;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] r_pix_addr;
  logic              r_rd_v;
  logic [2:0]        r_rgb;
  logic [PTR_W:0]    r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [2:0]        r_fifo_data [FIFO_DEPTH];

  assign w_active = (h_count < H_LIM) && (v_count < V_LIM);
  assign wr_ready = (r_count != CNT_FULL);
  assign w_push   = wr_valid && wr_ready;
  assign w_pop    = (w_grant == GR_WRITE);
  assign rgb      = r_rgb;

  // Per-cycle grant and memory port drive; everything idles while in reset.
  always_comb begin
    w_grant   = GR_IDLE;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (w_active) begin
        w_grant = GR_SCAN;
      end else if (r_count != '0) begin
        w_grant = GR_WRITE;
      end
    end
    case (w_grant)
      GR_SCAN: begin
        mem_en   = 1'b1;
        mem_addr = r_pix_addr;
      end
      GR_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_fifo_addr[r_rd_ptr];
        mem_wdata = r_fifo_data[r_rd_ptr];
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Scan address: advances on active cycles, restarts at every vertical blank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_addr <= '0;
    end else if (v_count >= V_LIM) begin
      r_pix_addr <= '0;
    end else if (w_active) begin
      r_pix_addr <= (r_pix_addr == LAST_PIX) ? '0 : r_pix_addr + ADDR_W'(1);
    end
  end

  // Two-stage read pipeline: issue -> RAM output -> rgb register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_v <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_rd_v <= (w_grant == GR_SCAN);
      r_rgb  <= r_rd_v ? mem_rdata : 3'b000;
    end
  end

  // FIFO occupancy and pointers; reset discards anything queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= wr_addr;
      r_fifo_data[r_wr_ptr] <= wr_data;
    end
  end

`ifdef VGA_FB_STALL_STAT_EN
  logic [15:0] r_stall;
  assign stall_count = r_stall;

  // Saturating count of refused writer cycles, cleared once per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if ((v_count == V_LIM) && (h_count == '0)) begin
      r_stall <= '0;
    end else if (wr_valid && !wr_ready && (r_stall != '1)) begin
      r_stall <= r_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter on a small raster: behavioural model (queue FIFO,
// pixel counter, framebuffer image, 2-deep rgb history) checked every cycle,
// plus directed literal checks.
module tb_vga_fb_arbiter;
  localparam int H     = 8;
  localparam int V     = 4;
  localparam int AW    = 6;
  localparam int DEPTH = 4;
  localparam int H_TOT = 12;
  localparam int V_TOT = 6;
  localparam int NPIX  = H * V;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic [10:0]   h_count  = '0;
  logic [9:0]    v_count  = 10'(V);
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [2:0]    wr_data  = '0;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_wdata;
  logic [2:0]    mem_rdata = '0;
  logic [2:0]    rgb;
`ifdef VGA_FB_STALL_STAT_EN
  logic [15:0]   stall_count;
`endif

  int checks = 0;
  int errors = 0;
  int rh = 0;
  int rv = 0;

  vga_fb_arbiter #(.H_SIZE(H), .V_SIZE(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rgb(rgb)
`ifdef VGA_FB_STALL_STAT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM driven by the DUT, preloaded with addr[2:0].
  logic [2:0] ram [2**AW];
  initial for (int i = 0; i < 2**AW; i++) ram[i] = 3'(i);
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [2:0]    d;
  } wr_t;
  wr_t        q[$];
  logic [2:0] hist[$];
  logic [2:0] fbm [2**AW];
  int         m_pix   = 0;
  int         m_stall = 0;
  initial for (int i = 0; i < 2**AW; i++) fbm[i] = 3'(i);

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clk) begin : compare
    logic       act;
    logic       full;
    logic [2:0] iss;
    wr_t        hd;
    if (reset) begin
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rgb", rgb, 0);
      chk("rst_wr_ready", wr_ready, 1);
`ifdef VGA_FB_STALL_STAT_EN
      chk("rst_stall", stall_count, 0);
`endif
      q.delete();
      hist.delete();
      hist.push_back(3'b000);
      hist.push_back(3'b000);
      m_pix   = 0;
      m_stall = 0;
    end else begin
      act  = (h_count < H) && (v_count < V);
      full = (q.size() == DEPTH);
      chk("wr_ready", wr_ready, !full);
      chk("rgb", rgb, hist[0]);
`ifdef VGA_FB_STALL_STAT_EN
      chk("stall_count", stall_count, m_stall);
`endif
      if (act) begin
        chk("scan_en", mem_en, 1);
        chk("scan_we", mem_we, 0);
        chk("scan_addr", mem_addr, m_pix);
      end else if (q.size() > 0) begin
        chk("wr_en", mem_en, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, q[0].a);
        chk("wr_data", mem_wdata, q[0].d);
      end else begin
        chk("idle_en", mem_en, 0);
        chk("idle_we", mem_we, 0);
        chk("idle_addr", mem_addr, 0);
        chk("idle_wdata", mem_wdata, 0);
      end
      iss = act ? fbm[m_pix] : 3'b000;
      hist.push_back(iss);
      void'(hist.pop_front());
      if (!act && q.size() > 0) begin
        hd = q.pop_front();
        fbm[hd.a] = hd.d;
      end
      if (wr_valid && !full) q.push_back(wr_t'{a: wr_addr, d: wr_data});
      if (v_count >= V)  m_pix = 0;
      else if (act)      m_pix = (m_pix + 1) % NPIX;
      if (v_count == V && h_count == 0)             m_stall = 0;
      else if (wr_valid && full && m_stall < 65535) m_stall++;
    end
  end

  task automatic drive(input int h, input int v, input logic wv, input int wa, input int wd);
    @(posedge clk);
    #1;
    h_count  = 11'(h);
    v_count  = 10'(v);
    wr_valid = wv;
    wr_addr  = AW'(wa);
    wr_data  = 3'(wd);
    #1;
  endtask

  task automatic tick(input logic wv, input int wa, input int wd);
    drive(rh, rv, wv, wa, wd);
    rh++;
    if (rh == H_TOT) begin
      rh = 0;
      rv = (rv + 1) % V_TOT;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("lit_rst_en", mem_en, 0);
    chk("lit_rst_rgb", rgb, 0);
    chk("lit_rst_ready", wr_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First pixels of a frame: addresses 0.., rgb = addr[2:0] two cycles later.
    rh = 0; rv = 0;
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 0, 0);
      if (i <= 4) begin
        chk("lit_scan_addr", mem_addr, i);
        chk("lit_scan_we", mem_we, 0);
        chk("lit_scan_en", mem_en, 1);
      end
      if (i >= 2) chk("lit_scan_rgb", rgb, i - 2);
    end

    // Six writes offered during line 1 active area; four fit, then drain in blank.
    while (!(rh == 0 && rv == 1)) tick(1'b0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tick(k < 6, 16 + k, k + 1);
      chk("lit_fifo_ready", wr_ready, (k < 4) ? 1 : 0);
    end
    for (int j = 0; j < 4; j++) begin
      tick(1'b0, 0, 0);
      chk("lit_drain_we", mem_we, 1);
      chk("lit_drain_addr", mem_addr, 16 + j);
      chk("lit_drain_data", mem_wdata, j + 1);
      if (j == 0) chk("lit_full_pop_ready", wr_ready, 0);
    end

    // Ten refused cycles against a full FIFO, then frame-start clear.
    drive(0, V, 1'b0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      drive(1, 0, 1'b1, 40 + k, k);
      chk("lit_stall_ready", wr_ready, (k < 4) ? 1 : 0);
    end
    drive(1, 0, 1'b0, 0, 0);
`ifdef VGA_FB_STALL_STAT_EN
    chk("lit_stall_10", stall_count, 10);
`endif
    drive(0, V, 1'b0, 0, 0);
    drive(3, V, 1'b0, 0, 0);
`ifdef VGA_FB_STALL_STAT_EN
    chk("lit_stall_clr", stall_count, 0);
`endif
    repeat (3) drive(8, V, 1'b0, 0, 0);

    // Blank write to pixel 5 shows up in the next frame's scan.
    drive(8, V, 1'b1, 5, 7);
    drive(9, V, 1'b0, 0, 0);
    chk("lit_px5_we", mem_we, 1);
    chk("lit_px5_addr", mem_addr, 5);
    chk("lit_px5_data", mem_wdata, 7);
    drive(9, V, 1'b0, 0, 0);
    chk("lit_idle_en", mem_en, 0);
    chk("lit_idle_addr", mem_addr, 0);
    rh = 0; rv = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 0, 0);
      if (i == 7) chk("lit_px5_rgb", rgb, 7);
    end

    // Full frame, then the next frame must start at address 0.
    while (!(rh == 0 && rv == 0)) tick(1'b0, 0, 0);
    tick(1'b0, 0, 0);
    chk("lit_frame_start", mem_addr, 0);

    // Wrap after the last pixel, and forced restart in vertical blank.
    drive(0, V, 1'b0, 0, 0);
    for (int k = 0; k < 34; k++) begin
      drive(2, 1, 1'b0, 0, 0);
      if (k == 0 || k == 31 || k == 32 || k == 33) chk("lit_wrap_addr", mem_addr, k % NPIX);
    end
    repeat (5) drive(3, 2, 1'b0, 0, 0);
    drive(20, V + 1, 1'b0, 0, 0);
    drive(0, 0, 1'b0, 0, 0);
    chk("lit_vblank_force", mem_addr, 0);

    // Reset mid-frame with three writes queued.
    rh = 0; rv = 1;
    for (int k = 0; k < 3; k++) tick(1'b1, 50 + k, 7);
    tick(1'b0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("lit_rst2_en", mem_en, 0);
    chk("lit_rst2_we", mem_we, 0);
    chk("lit_rst2_rgb", rgb, 0);
    chk("lit_rst2_ready", wr_ready, 1);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    h_count  = '0;
    v_count  = 10'(V);
    wr_valid = 1'b0;
    rh = 4; rv = 1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 0, 0);
      if (i == 4) chk("lit_no_stale_write", mem_en, 0);
    end

    // Randomized traffic: raster timing first, then arbitrary counters.
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) begin
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      if (n < 700)
        tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
      else
        drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
    end

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
